// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and clear sequencer for a single-port data memory.
// After reset it can zero-fill the whole memory before serving any requester.
// Requester 0 is the processor core and requester 1 is the test/debug loader.
// The grant is combinational, and the access executes in the same cycle.
// Read data comes back one cycle after the grant, on registered outputs.
//
// Ports:
//   Clk, Reset                      clock; synchronous active-high reset
//   Busy                            clear sweep in progress (no grants)
//   Req0/1, We0/1, Addr0/1, WData0/1  requester access (We=1 write, 0 read)
//   Gnt0/1                          combinational grant, access executes this cycle
//   RValid0/1, RData0/1             registered read return, one cycle after a read grant
//   MemWe, MemAddr, MemWData        memory command bus
//   MemRData                        combinational memory read data for MemAddr
module dmem_arbiter #(
  parameter int unsigned AW             = 8,
  parameter int unsigned DW             = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic          Clk,
  input  logic          Reset,
  output logic          Busy,
  input  logic          Req0,
  input  logic          We0,
  input  logic [AW-1:0] Addr0,
  input  logic [DW-1:0] WData0,
  input  logic          Req1,
  input  logic          We1,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] WData1,
  output logic          Gnt0,
  output logic          Gnt1,
  output logic          RValid0,
  output logic          RValid1,
  output logic [DW-1:0] RData0,
  output logic [DW-1:0] RData1,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData
);

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic {CLEAR, ARB} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;   // index of the most recently granted port
  logic          rd0, rd1;

  assign rd0 = Gnt0 & ~We0;
  assign rd1 = Gnt1 & ~We1;

  // State, sweep counter, round-robin pointer and read-return registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= CLEAR_ON_RESET ? CLEAR : ARB;
      cnt     <= '0;
      last    <= 1'b1;
      RValid0 <= 1'b0;
      RValid1 <= 1'b0;
      RData0  <= '0;
      RData1  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      RValid0 <= rd0;
      RValid1 <= rd1;
      if (rd0) RData0 <= MemRData;
      if (rd1) RData1 <= MemRData;
    end
  end

  // Next state, grant selection and memory bus mux
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    Busy      = 1'b0;
    Gnt0      = 1'b0;
    Gnt1      = 1'b0;
    MemWe     = 1'b0;
    MemAddr   = '0;
    MemWData  = '0;

    case (state)
      CLEAR: begin
        Busy    = 1'b1;
        MemWe   = 1'b1;
        MemAddr = cnt;
        cnt_nxt = cnt + AW'(1);   // wraps to 0 on the final address
        if (cnt == LAST_ADDR) state_nxt = ARB;
      end
      ARB: begin
        // On a tie the port that was not served last wins
        if (Req0 && (!Req1 || last)) Gnt0 = 1'b1;
        else if (Req1)               Gnt1 = 1'b1;
      end
      default: state_nxt = CLEAR_ON_RESET ? CLEAR : ARB;
    endcase

    if (Reset) begin
      Gnt0 = 1'b0;
      Gnt1 = 1'b0;
    end

    if (Gnt0) begin
      MemWe    = We0;
      MemAddr  = Addr0;
      MemWData = WData0;
      last_nxt = 1'b0;
    end else if (Gnt1) begin
      MemWe    = We1;
      MemAddr  = Addr1;
      MemWData = WData1;
      last_nxt = 1'b1;
    end

    if (Reset) MemWe = 1'b0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by a random phase.
// All results are checked against a transaction-level reference model of the
// memory, the sweep and the round-robin grants. A second instance built with
// CLEAR_ON_RESET=0 covers immediate service after reset.
module tb_dmem_arbiter;

  logic       Clk;
  logic       Reset;
  logic       Busy;
  logic       Req0, We0, Req1, We1;
  logic [7:0] Addr0, WData0, Addr1, WData1;
  logic       Gnt0, Gnt1, RValid0, RValid1;
  logic [7:0] RData0, RData1;
  logic       MemWe;
  logic [7:0] MemAddr, MemWData, MemRData;

  logic       n_reset, n_busy, n_req0, n_we0, n_req1, n_we1;
  logic [7:0] n_addr0, n_wdata0, n_addr1, n_wdata1;
  logic       n_gnt0, n_gnt1, n_rvalid0, n_rvalid1;
  logic [7:0] n_rdata0, n_rdata1;
  logic       n_memwe;
  logic [7:0] n_memaddr, n_memwdata, n_memrdata;

  logic       preload;
  logic [7:0] mem   [256];
  logic [7:0] mem_n [256];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] ref_mem [256];
  int         clr_left;
  int         m_last;
  logic       exp_rv [2];
  logic [7:0] exp_rd [2];
  int         busy_cnt;

  dmem_arbiter dut (
    .Clk(Clk), .Reset(Reset), .Busy(Busy),
    .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0),
    .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1),
    .RValid0(RValid0), .RValid1(RValid1), .RData0(RData0), .RData1(RData1),
    .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData)
  );

  dmem_arbiter #(.CLEAR_ON_RESET(1'b0)) dut_n (
    .Clk(Clk), .Reset(n_reset), .Busy(n_busy),
    .Req0(n_req0), .We0(n_we0), .Addr0(n_addr0), .WData0(n_wdata0),
    .Req1(n_req1), .We1(n_we1), .Addr1(n_addr1), .WData1(n_wdata1),
    .Gnt0(n_gnt0), .Gnt1(n_gnt1),
    .RValid0(n_rvalid0), .RValid1(n_rvalid1), .RData0(n_rdata0), .RData1(n_rdata1),
    .MemWe(n_memwe), .MemAddr(n_memaddr), .MemWData(n_memwdata), .MemRData(n_memrdata)
  );

  // Memories behind each instance; preload sets known contents
  always @(posedge Clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hFF;
    end else if (MemWe) begin
      mem[MemAddr] <= MemWData;
    end
  end

  always @(posedge Clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem_n[i] <= 8'(i) ^ 8'h5A;
    end else if (n_memwe) begin
      mem_n[n_memaddr] <= n_memwdata;
    end
  end

  assign MemRData   = mem[MemAddr];
  assign n_memrdata = mem_n[n_memaddr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on the main instance. The task is entered at a negedge and returns at the next negedge.
  task automatic step(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                      input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                      output int g);
    logic       e_busy, e_we;
    logic [7:0] e_addr, e_wd;
    chk("rvalid0", 32'(RValid0), 32'(exp_rv[0]));
    chk("rvalid1", 32'(RValid1), 32'(exp_rv[1]));
    chk("rdata0",  32'(RData0),  32'(exp_rd[0]));
    chk("rdata1",  32'(RData1),  32'(exp_rd[1]));
    Req0 = r0; We0 = w0; Addr0 = a0; WData0 = d0;
    Req1 = r1; We1 = w1; Addr1 = a1; WData1 = d1;
    #1;
    g = -1;
    e_busy = 1'b0; e_we = 1'b0; e_addr = 8'h00; e_wd = 8'h00;
    if (clr_left > 0) begin
      e_busy = 1'b1;
      e_we   = 1'b1;
      e_addr = 8'(256 - clr_left);
    end else begin
      if (r0 && r1) g = (m_last == 1) ? 0 : 1;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
      if (g == 0) begin e_we = w0; e_addr = a0; e_wd = d0; end
      if (g == 1) begin e_we = w1; e_addr = a1; e_wd = d1; end
    end
    if (Busy === 1'b1) busy_cnt++;
    chk("busy",     32'(Busy),     32'(e_busy));
    chk("gnt0",     32'(Gnt0),     32'(g == 0));
    chk("gnt1",     32'(Gnt1),     32'(g == 1));
    chk("gnt_excl", 32'(Gnt0 & Gnt1), 32'(0));
    chk("memwe",    32'(MemWe),    32'(e_we));
    chk("memaddr",  32'(MemAddr),  32'(e_addr));
    chk("memwdata", 32'(MemWData), 32'(e_wd));
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (clr_left > 0) begin
      ref_mem[e_addr] = 8'h00;
      clr_left--;
    end else if (g >= 0) begin
      m_last = g;
      if (e_we) ref_mem[e_addr] = e_wd;
      else begin
        exp_rv[g] = 1'b1;
        exp_rd[g] = ref_mem[e_addr];
      end
    end
    @(negedge Clk);
  endtask

  // Hold reset for n edges with both ports requesting, then release at a negedge
  task automatic do_reset(input int n);
    Reset = 1'b1;
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 8'h44; WData0 = 8'h00;
    Req1 = 1'b1; We1 = 1'b1; Addr1 = 8'h45; WData1 = 8'h99;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_gnt0",  32'(Gnt0),  32'(0));
      chk("rst_gnt1",  32'(Gnt1),  32'(0));
      chk("rst_memwe", 32'(MemWe), 32'(0));
      @(negedge Clk);
      chk("rst_rvalid0", 32'(RValid0), 32'(0));
      chk("rst_rvalid1", 32'(RValid1), 32'(0));
      chk("rst_rdata0",  32'(RData0),  32'(0));
      chk("rst_rdata1",  32'(RData1),  32'(0));
    end
    Reset = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0;
    clr_left  = 256;
    m_last    = 1;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
  endtask

  initial begin
    int g, cyc, gcyc;
    int seq [6];
    logic       p_req [2];
    logic       p_we  [2];
    logic [7:0] p_a   [2];
    logic [7:0] p_d   [2];

    Reset = 1'b1; n_reset = 1'b1; preload = 1'b1;
    Req0 = 0; We0 = 0; Addr0 = 0; WData0 = 0;
    Req1 = 0; We1 = 0; Addr1 = 0; WData1 = 0;
    n_req0 = 0; n_we0 = 0; n_addr0 = 0; n_wdata0 = 0;
    n_req1 = 0; n_we1 = 0; n_addr1 = 0; n_wdata1 = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'hFF;
    clr_left = 0; m_last = 1; busy_cnt = 0;
    exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = 0; exp_rd[1] = 0;

    @(negedge Clk);
    preload = 1'b0;

    // CLEAR_ON_RESET=0 instance: the grant is forced off while in reset, then served immediately
    n_req0 = 1'b1; n_we0 = 1'b0; n_addr0 = 8'h33;
    #1;
    chk("n_rst_gnt0", 32'(n_gnt0), 32'(0));
    chk("n_rst_rvalid0", 32'(n_rvalid0), 32'(0));
    @(negedge Clk);
    n_reset = 1'b0;
    #1;
    chk("n_gnt0",    32'(n_gnt0),    32'(1));
    chk("n_busy",    32'(n_busy),    32'(0));
    chk("n_memaddr", 32'(n_memaddr), 32'(8'h33));
    chk("n_memwe",   32'(n_memwe),   32'(0));
    @(negedge Clk);
    n_req0 = 1'b0;
    chk("n_rvalid0", 32'(n_rvalid0), 32'(1));
    chk("n_rdata0",  32'(n_rdata0),  32'(8'h33 ^ 8'h5A));
    @(negedge Clk);
    chk("n_rvalid0_pulse", 32'(n_rvalid0), 32'(0));
    chk("n_rdata0_hold",   32'(n_rdata0),  32'(8'h69));

    // Main instance: reset, then a sweep that is interrupted at cycle 100
    do_reset(2);
    for (int k = 0; k < 100; k++) step(0, 0, 0, 0, 0, 0, 0, 0, g);
    do_reset(1);

    // Full sweep. Port 1 raises a read at cycle 50 and holds it until granted.
    busy_cnt = 0;
    cyc = 0;
    for (int k = 0; k < 50; k++) begin step(0, 0, 0, 0, 0, 0, 0, 0, g); cyc++; end
    g = -1; gcyc = -1;
    while (g != 1 && cyc < 400) begin
      step(0, 0, 0, 0, 1, 0, 8'h7F, 0, g);
      if (g == 1) gcyc = cyc;
      cyc++;
    end
    chk("first_gnt1_cycle", 32'(gcyc), 32'(256));
    chk("busy_cycles", 32'(busy_cnt), 32'(256));

    // Port 0 reads a swept location
    step(1, 0, 8'h7F, 0, 0, 0, 0, 0, g);
    chk("rd7f_rvalid0", 32'(RValid0), 32'(1));
    chk("rd7f_rdata0",  32'(RData0),  32'(8'h00));

    // Write followed by a read of the same address
    step(1, 1, 8'h10, 8'hA5, 0, 0, 0, 0, g);
    chk("wr_gnt", 32'(g), 32'(0));
    step(1, 0, 8'h10, 0, 0, 0, 0, 0, g);
    chk("rd_gnt", 32'(g), 32'(0));
    chk("raw_rvalid0", 32'(RValid0), 32'(1));
    chk("raw_rdata0",  32'(RData0),  32'(8'hA5));

    // Port 1 write makes port 0 the next winner, then 6 cycles of contention
    step(0, 0, 0, 0, 1, 1, 8'h20, 8'h3C, g);
    for (int i = 0; i < 6; i++) step(1, 0, 8'h10, 0, 1, 0, 8'h20, 0, seq[i]);
    for (int i = 0; i < 6; i++) chk("contend_order", 32'(seq[i]), 32'(i % 2));
    step(0, 0, 0, 0, 0, 0, 0, 0, g);

    // Random traffic. Each port holds its request until it is granted.
    p_req[0] = 0; p_req[1] = 0;
    p_we[0] = 0; p_we[1] = 0;
    p_a[0] = 0; p_a[1] = 0;
    p_d[0] = 0; p_d[1] = 0;
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] && $urandom_range(0, 9) < 6) begin
          p_req[p] = 1'b1;
          p_we[p]  = 1'($urandom_range(0, 1));
          p_a[p]   = 8'($urandom_range(0, 15));
          p_d[p]   = 8'($urandom);
        end
      end
      step(p_req[0], p_we[0], p_a[0], p_d[0], p_req[1], p_we[1], p_a[1], p_d[1], g);
      if (g >= 0) p_req[g] = 1'b0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, g);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer in front of the single-port 256 x 8 data memory of the 3BC processor. It shares the memory between two requesters: port 0, the processor core, and port 1, the test/debug loader. Arbitration is round-robin, with at most one memory access per cycle. After reset it optionally sweeps the whole memory to zero before any requester is served. Read data returns on a registered, one-cycle-latency path.

## Interface
- AW, 8: memory address width; depth is 2^AW.
- DW, 8: data width.
- CLEAR_ON_RESET, 1: if 1, zero-fill the memory after reset; if 0, go straight to arbitration.

- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Busy  out  1  high while the clear sweep runs; no grants are issued.
- Req0 / Req1  in  1  access request, port 0 / port 1.
- We0 / We1  in  1  1 = write, 0 = read; valid with Req.
- Addr0 / Addr1  in  AW  access address.
- WData0 / WData1  in  DW  write data.
- Gnt0 / Gnt1  out  1  combinational grant; the access executes this cycle.
- RValid0 / RValid1  out  1  read data valid, one cycle after a read grant.
- RData0 / RData1  out  DW  registered read data.
- MemWe  out  1  memory write enable.
- MemAddr  out  AW  memory address.
- MemWData  out  DW  memory write data.
- MemRData  in  DW  combinational memory read data for MemAddr.

## Operation
- The FSM has two states: CLEAR and ARB.
- Reset behaviour:
  - Reset sampled high sets state to CLEAR (CLEAR_ON_RESET=1) or ARB (CLEAR_ON_RESET=0).
  - It also sets clear counter = 0, Last = 1, RValid0/1 = 0 and RData0/1 = 0.
  - While Reset is high: Gnt0/1 = 0 and MemWe = 0, forced combinationally.
- CLEAR state:
  - Outputs: Busy = 1, MemWe = 1, MemAddr = counter, MemWData = 0, no grants.
  - Counter increments by 1 each cycle.
  - When counter = 2^AW - 1, the next state is ARB; the counter wraps to 0 and holds there.
  - Requests raised during CLEAR are ignored. Requesters hold Req; nothing is lost.
- ARB state, Busy = 0:
  - Only Req0 asserted: Gnt0 = 1.
  - Only Req1 asserted: Gnt1 = 1.
  - Both asserted: grant the port not equal to Last. After reset Last = 1, so port 0 wins the first tie.
  - Neither asserted: no grant, MemWe = 0, MemAddr = 0, MemWData = 0.
  - On any grant, Last takes the granted port index at the edge. With no grant, Last holds.
  - The memory bus is muxed from the granted port: MemWe = WeN, MemAddr = AddrN, MemWData = WDataN.
- Read return:
  - On a granted read (WeN = 0), RDataN <= MemRData and RValidN <= 1 at the grant edge.
  - Otherwise RValidN <= 0; RDataN holds its last value.
- Handshake: a requester holds Req, We, Addr and WData stable until it sees Gnt. A requester may keep Req high to issue back-to-back accesses.
- Gnt0 and Gnt1 are never high together.
- Reset mid-sweep restarts CLEAR at address 0. Reset mid-read suppresses the pending RValid.

## Timing
- Clear sweep, cycles numbered from the first edge with Reset low:
  - Cycles 0..2^AW-1 write address k in cycle k.
  - The first grant is possible in cycle 2^AW; Busy falls in the same cycle.
- Grant latency is 0 cycles: Gnt is combinational from Req in the same cycle.
- Read latency: RValid and RData are valid in the cycle after Gnt, for exactly one cycle per read.
- Write completes at the grant edge; a read of the same address in the next cycle returns the new value.
- Throughput is one access per cycle.
- Under continuous contention, grants alternate 0,1,0,1. Worst-case wait is 1 cycle.

## Test plan
- Reset then release, CLEAR_ON_RESET=1, memory preloaded with 0xFF:
  - Busy high for exactly 256 cycles; MemAddr steps 0x00..0xFF with MemWData = 0.
  - Port 0 read of 0x7F afterwards -> RValid0 = 1 and RData0 = 0x00 one cycle after Gnt0.
- Port 0 writes 0xA5 to 0x10, then reads 0x10 the next cycle -> Gnt0 in both cycles; RData0 = 0xA5 with RValid0 one cycle after the read grant.
- Req0 and Req1 both held high for 6 cycles, all reads -> grant order 0,1,0,1,0,1. Never both grants high; each RValid pulses in the cycle after its own grant.
- Req1 asserted during CLEAR at cycle 50 and held -> Gnt1 = 0 until cycle 256, then Gnt1 = 1 in cycle 256.
- Reset asserted at sweep cycle 100 -> sweep restarts at address 0 and runs a full 256 cycles; no grant in between.
- CLEAR_ON_RESET=0, Req0 read at the first cycle after reset -> Gnt0 = 1 immediately; RValid0 = 1 next cycle with the preexisting memory value.
